// File: rtl/div_arbiter.sv
// Shared iterative restoring divider time-multiplexed between two requesters.
// One quotient bit per clock; round-robin grant on contention; saturating result.
`timescale 1ns/1ps
module div_arbiter #(
    parameter int DW = 30,
    parameter int VW = 16,
    parameter int QW = 12
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          req_a,
    input  logic [DW-1:0] dvd_a,
    input  logic [VW-1:0] dvs_a,
    input  logic          req_b,
    input  logic [DW-1:0] dvd_b,
    input  logic [VW-1:0] dvs_b,
    output logic          ack_a,
    output logic          ack_b,
    output logic [QW-1:0] quotient,
    output logic          sat,
    output logic          dz,
    output logic          busy
);
    localparam int CW = $clog2(DW);

    typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

    state_t        r_state;
    logic [DW-1:0] r_dq;      // dividend shifts out the top, quotient bits shift in the bottom
    logic [VW-1:0] r_dvs;
    logic [VW-1:0] r_rem;
    logic [CW-1:0] r_cnt;
    logic          r_gnt_b;
    logic          r_a_next;

    logic          w_sel_b;
    logic [VW:0]   w_shift;
    logic          w_ge;
    logic [VW-1:0] w_diff;
    logic          w_ovf;

    assign w_sel_b = req_b & (~req_a | ~r_a_next);
    assign w_shift = {r_rem, r_dq[DW-1]};
    assign w_ge    = (w_shift >= {1'b0, r_dvs});
    // True difference is below the divisor, so the low VW bits are exact.
    assign w_diff  = w_shift[VW-1:0] - r_dvs;
    assign w_ovf   = |r_dq[DW-1:QW];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_dq     <= '0;
            r_dvs    <= '0;
            r_rem    <= '0;
            r_cnt    <= '0;
            r_gnt_b  <= 1'b0;
            r_a_next <= 1'b1;
            ack_a    <= 1'b0;
            ack_b    <= 1'b0;
            quotient <= '0;
            sat      <= 1'b0;
            dz       <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    ack_a <= 1'b0;
                    ack_b <= 1'b0;
                    if (req_a | req_b) begin
                        r_gnt_b  <= w_sel_b;
                        r_a_next <= w_sel_b;
                        r_dq     <= w_sel_b ? dvd_b : dvd_a;
                        r_dvs    <= w_sel_b ? dvs_b : dvs_a;
                        r_rem    <= '0;
                        r_cnt    <= CW'(DW - 1);
                        r_state  <= DIV;
                        busy     <= 1'b1;
                    end
                end
                DIV: begin
                    ack_a <= 1'b0;
                    ack_b <= 1'b0;
                    r_rem <= w_ge ? w_diff : w_shift[VW-1:0];
                    r_dq  <= {r_dq[DW-2:0], w_ge};
                    if (r_cnt == '0) r_state <= DONE;
                    else             r_cnt   <= r_cnt - 1'b1;
                end
                DONE: begin
                    ack_a   <= ~r_gnt_b;
                    ack_b   <= r_gnt_b;
                    if (r_dvs == '0) begin
                        quotient <= '1;
                        sat      <= 1'b0;
                        dz       <= 1'b1;
                    end else begin
                        quotient <= w_ovf ? '1 : r_dq[QW-1:0];
                        sat      <= w_ovf;
                        dz       <= 1'b0;
                    end
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_div_arbiter.sv
// Self-checking bench for div_arbiter: directed cases plus random traffic
// against a transaction-level timeline model of grants, latency and results.
`timescale 1ns/1ps
module tb_div_arbiter;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_a = 1'b0, req_b = 1'b0;
    logic [29:0] dvd_a = '0, dvd_b = '0;
    logic [15:0] dvs_a = '0, dvs_b = '0;
    logic        ack_a, ack_b, sat, dz, busy;
    logic [11:0] quotient;

    div_arbiter #(.DW(30), .VW(16), .QW(12)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_a(req_a), .dvd_a(dvd_a), .dvs_a(dvs_a),
        .req_b(req_b), .dvd_b(dvd_b), .dvs_b(dvs_b),
        .ack_a(ack_a), .ack_b(ack_b), .quotient(quotient),
        .sat(sat), .dz(dz), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Timeline model: an op sampled at edge k acks at edge k+31; next sample at k+32.
    longint      k = 0;
    bit          m_act, m_gb, m_a_next;
    logic [29:0] m_dvd;
    logic [15:0] m_dvs;
    longint      m_ack_edge, m_next;
    logic [11:0] m_q;
    bit          m_sat, m_dz, e_ack_a, e_ack_b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_act = 0; m_gb = 0; m_a_next = 1; m_next = 0;
        m_q = '0; m_sat = 0; m_dz = 0; e_ack_a = 0; e_ack_b = 0;
    endtask

    task automatic model_edge();
        longint fq;
        e_ack_a = 0; e_ack_b = 0;
        if (!reset_n) return;
        k++;
        if (m_act && k == m_ack_edge) begin
            m_act = 0;
            if (m_dvs == 0) begin
                m_q = 12'hFFF; m_sat = 0; m_dz = 1;
            end else begin
                fq = longint'(m_dvd) / longint'(m_dvs);
                m_dz = 0;
                if (fq >= 4096) begin m_q = 12'hFFF; m_sat = 1; end
                else begin m_q = 12'(fq); m_sat = 0; end
            end
            if (m_gb) e_ack_b = 1; else e_ack_a = 1;
        end
        if (!m_act && k >= m_next && (req_a || req_b)) begin
            m_gb       = req_b && (!req_a || !m_a_next);
            m_a_next   = m_gb;
            m_dvd      = m_gb ? dvd_b : dvd_a;
            m_dvs      = m_gb ? dvs_b : dvs_a;
            m_ack_edge = k + 31;
            m_next     = k + 32;
            m_act      = 1;
        end
    endtask

    task automatic check_outputs();
        chk("ack_a",    32'(ack_a),         32'(e_ack_a));
        chk("ack_b",    32'(ack_b),         32'(e_ack_b));
        chk("busy",     32'(busy),          32'(m_act));
        chk("quotient", 32'(quotient),      32'(m_q));
        chk("sat",      32'(sat),           32'(m_sat));
        chk("dz",       32'(dz),            32'(m_dz));
        chk("overlap",  32'(ack_a & ack_b), 32'(0));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic wait_ack(input int max, output bit ga, output bit gb);
        ga = 0; gb = 0;
        for (int i = 0; i < max; i++) begin
            tick();
            if (ack_a || ack_b) begin ga = ack_a; gb = ack_b; return; end
        end
        n_assert++;
        n_fail++;
        $error("FAIL ack_timeout: no ack within %0d cycles, required one", max);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        #1;
        check_outputs();
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic new_ops(output logic [29:0] d, output logic [15:0] v);
        int r;
        r = $urandom_range(0, 15);
        if (r == 0)      v = '0;
        else if (r < 8)  v = 16'($urandom_range(1, 255));
        else             v = 16'($urandom);
        if ($urandom_range(0, 1) == 1) d = 30'($urandom & 32'h3FFF_FFFF);
        else                           d = 30'($urandom_range(0, 1 << 20));
    endtask

    initial begin
        bit ga, gb;
        longint k0, kprev;

        // Reset state
        model_reset();
        do_reset();

        // Single op on A with exact latency and value
        req_a = 1; dvd_a = 30'd123400; dvs_a = 16'd100;
        tick(); k0 = k;
        req_b = 0;
        wait_ack(40, ga, gb);
        req_a = 0;
        chk("single_ack_a", 32'(ga), 32'(1));
        chk("single_latency", 32'(k - k0), 32'(31));
        chk("single_q", 32'(quotient), 32'(1234));
        chk("single_sat_dz", 32'({sat, dz}), 32'(0));
        tick();

        // Operand change after latching has no effect
        req_a = 1; dvd_a = 30'd123400; dvs_a = 16'd100;
        tick(); tick();
        dvd_a = '0;
        wait_ack(40, ga, gb);
        req_a = 0;
        chk("latched_q", 32'(quotient), 32'(1234));
        tick();

        // Contention: A first after reset, then strict alternation 32 cycles apart
        do_reset();
        req_a = 1; dvd_a = 30'd5000; dvs_a = 16'd7;
        req_b = 1; dvd_b = 30'd90000; dvs_b = 16'd300;
        kprev = 0;
        for (int i = 0; i < 4; i++) begin
            wait_ack(40, ga, gb);
            chk("rr_order", 32'(gb), 32'(i % 2));
            if (i > 0) chk("rr_spacing", 32'(k - kprev), 32'(32));
            kprev = k;
        end
        req_a = 0; req_b = 0;
        tick();

        // Saturation and divide-by-zero on B
        req_b = 1; dvd_b = 30'd1000000; dvs_b = 16'd10;
        wait_ack(40, ga, gb);
        req_b = 0;
        chk("sat_ack_b", 32'(gb), 32'(1));
        chk("sat_q", 32'(quotient), 32'(4095));
        chk("sat_flag", 32'({sat, dz}), 32'(2));
        tick();
        req_b = 1; dvs_b = 16'd0;
        wait_ack(40, ga, gb);
        req_b = 0;
        chk("dz_q", 32'(quotient), 32'(4095));
        chk("dz_flag", 32'({sat, dz}), 32'(1));
        tick();

        // Reset in the middle of DIV discards the op
        req_a = 1; dvd_a = 30'd777777; dvs_a = 16'd3;
        tick();
        for (int i = 0; i < 10; i++) tick();
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("rst_mid_q", 32'(quotient), 32'(0));
        chk("rst_mid_busy", 32'(busy), 32'(0));
        check_outputs();
        req_a = 0;
        tick(); tick();
        reset_n = 1'b1;
        for (int i = 0; i < 40; i++) tick();
        req_a = 1; dvd_a = 30'd123400; dvs_a = 16'd100;
        wait_ack(40, ga, gb);
        req_a = 0;
        chk("post_rst_q", 32'(quotient), 32'(1234));
        tick();

        // Random traffic
        for (int c = 0; c < 60000; c++) begin
            tick();
            ga = ack_a; gb = ack_b;
            if (ga) begin
                if ($urandom_range(0, 1) == 1) begin new_ops(dvd_a, dvs_a); req_a = 1; end
                else req_a = 0;
            end else if (!req_a && !(m_act && !m_gb)) begin
                if ($urandom_range(0, 3) == 0) begin new_ops(dvd_a, dvs_a); req_a = 1; end
            end else if (req_a && m_act && !m_gb) begin
                case ($urandom_range(0, 15))
                    0: req_a = 0;
                    1: dvd_a = 30'($urandom);
                    default: ;
                endcase
            end
            if (gb) begin
                if ($urandom_range(0, 1) == 1) begin new_ops(dvd_b, dvs_b); req_b = 1; end
                else req_b = 0;
            end else if (!req_b && !(m_act && m_gb)) begin
                if ($urandom_range(0, 3) == 0) begin new_ops(dvd_b, dvs_b); req_b = 1; end
            end else if (req_b && m_act && m_gb) begin
                case ($urandom_range(0, 15))
                    0: req_b = 0;
                    1: dvs_b = 16'($urandom);
                    default: ;
                endcase
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
